// File: rtl/credit_link_tx_pkg.sv
// Shared types and helpers for the credit-based link transmitter.
package credit_link_tx_pkg;

  // Usable downstream FIFO capacity for a given pointer width.
  function automatic int unsigned cred_max(input int unsigned depth_width);
    return (1 << depth_width) - 1;
  endfunction

  // Packet framing state.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/credit_link_tx_credit_counter.sv
// Saturating free-slot counter for the downstream FIFO.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (count resets to MAX)
//   dec_i         : one slot consumed (flit written downstream)
//   inc_i         : one slot freed (credit returned)
//   count_o       : registered free-slot count
//   nonzero_o     : count_o != 0 (combinational from the register)
//   err_o         : registered one-cycle pulse on a credit while already at MAX
module credit_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             nonzero_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Next count: simultaneous inc/dec cancel; an increment at MAX is dropped and flagged.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == MaxVal) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec_i && !inc_i) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= MaxVal;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  assign err_o     = err_q;

endmodule

// File: rtl/credit_link_tx.sv
// Credit-based link transmitter: accepts flits over valid/ready and writes them
// into the downstream FIFO, never exceeding the credits it holds. Tracks packet
// framing (head/body vs tail) for observability only.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   data_i, last_i, valid_i: flit from local output stage; ready_o = credits != 0
//   data_o, wr_en_o        : registered write to downstream FIFO
//   credit_i               : one pulse per downstream FIFO read
//   credits_o              : free downstream slots
//   pkt_active_o           : head sent, tail not yet sent
//   credit_err_o           : credit returned while already at full credit
module credit_link_tx
  import credit_link_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH_WIDTH = 2,
  parameter int unsigned ID               = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        last_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        wr_en_o,
  input  logic                        credit_i,
  output logic [FIFO_DEPTH_WIDTH-1:0] credits_o,
  output logic                        pkt_active_o,
  output logic                        credit_err_o
);

  localparam int unsigned CredMax = cred_max(FIFO_DEPTH_WIDTH);

  logic                  accept;
  logic                  has_credit;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_en_q;
  tx_state_t             state_q, state_d;

  assign ready_o = has_credit;
  assign accept  = valid_i && has_credit;

  credit_counter #(
    .WIDTH (FIFO_DEPTH_WIDTH),
    .MAX   (CredMax)
  ) u_credit_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .dec_i     (accept),
    .inc_i     (credit_i),
    .count_o   (credits_o),
    .nonzero_o (has_credit),
    .err_o     (credit_err_o)
  );

  // Downstream write register: one-cycle strobe per accepted flit, data held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o  = data_q;
  assign wr_en_o = wr_en_q;

  // Framing state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing next state: any accepted non-tail flit leaves/keeps us in a packet.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !last_i) state_d = PKT;
      PKT:  if (accept && last_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pkt_active_o = (state_q == PKT);

  // The counter guards acceptance; an accept with zero credits means the guard broke.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(valid_i && ready_o && credits_o == '0))
        else $error("credit_link_tx[%0d]: flit accepted with no credits", ID);
    end
  end

endmodule

// File: tb/tb_credit_link_tx.sv
module tb_credit_link_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 2;
  localparam int CMAX = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          last_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          wr_en_o;
  logic          credit_i = 1'b0;
  logic [FW-1:0] credits_o;
  logic          pkt_active_o;
  logic          credit_err_o;

  int compared = 0;
  int mismatched = 0;

  // Reference model state (what the outputs should show after the last edge).
  int       m_credits;
  bit       m_pkt;
  bit       m_wr;
  bit       m_err;
  bit [7:0] m_data;

  always #5 clk_i = ~clk_i;

  credit_link_tx #(
    .DATA_WIDTH       (DW),
    .FIFO_DEPTH_WIDTH (FW),
    .ID               (0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .last_i       (last_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .wr_en_o      (wr_en_o),
    .credit_i     (credit_i),
    .credits_o    (credits_o),
    .pkt_active_o (pkt_active_o),
    .credit_err_o (credit_err_o)
  );

  typedef struct {
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       credit;
    logic       exp_wr;
    logic [7:0] exp_data;
    logic [1:0] exp_cred;
    logic       exp_rdy;
    logic       exp_pkt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = CMAX;
    m_pkt = 0;
    m_wr = 0;
    m_err = 0;
    m_data = 8'h00;
  endtask

  // Advance the model by one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit acc;
    acc = valid_i && (m_credits != 0);
    m_wr = acc;
    if (acc) m_data = data_i;
    if (acc) m_pkt = !last_i;
    m_credits = m_credits + int'(credit_i) - int'(acc);
    m_err = 0;
    if (m_credits > CMAX) begin
      m_credits = CMAX;
      m_err = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wr_en"},  32'(wr_en_o),      32'(m_wr));
    check({tag, ".data"},   32'(data_o),       32'(m_data));
    check({tag, ".credits"},32'(credits_o),    32'(m_credits));
    check({tag, ".ready"},  32'(ready_o),      32'(m_credits != 0));
    check({tag, ".pkt"},    32'(pkt_active_o), 32'(m_pkt));
    check({tag, ".err"},    32'(credit_err_o), 32'(m_err));
  endtask

  task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic c);
    valid_i  = v;
    last_i   = l;
    data_i   = d;
    credit_i = c;
  endtask

  // Drive, take one edge in both DUT and model, sample #1 later.
  task automatic cycle(input logic v, input logic l, input logic [7:0] d, input logic c);
    drive(v, l, d, c);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Expected values after each edge, starting from reset (credits = 3).
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 8'h33, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h33, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 8'h66, 2'd2, 1'b1, 1'b0, 1'b0};

    // Reset values.
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_model("reset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed table: fill to zero credits, stall, credit/accept overlap, overflow.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].credit);
      model_step();
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d.wr_en", i),   32'(wr_en_o),      32'(vecs[i].exp_wr));
      check($sformatf("vec%0d.data", i),    32'(data_o),       32'(vecs[i].exp_data));
      check($sformatf("vec%0d.credits", i), 32'(credits_o),    32'(vecs[i].exp_cred));
      check($sformatf("vec%0d.ready", i),   32'(ready_o),      32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d.pkt", i),     32'(pkt_active_o), 32'(vecs[i].exp_pkt));
      check($sformatf("vec%0d.err", i),     32'(credit_err_o), 32'(vecs[i].exp_err));
    end

    // ready_o must not depend on valid_i while credits are available.
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check("ready_indep_valid", 32'(ready_o), 32'd1);

    // Mid-packet async reset with credits = 1.
    cycle(1'b1, 1'b0, 8'h77, 1'b0);   // credits 2 -> 1, head flit
    check_model("pre_reset");
    check("pre_reset.cred1", 32'(credits_o), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_model("async_reset");
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Three flits accepted without any credits after release.
    cycle(1'b1, 1'b0, 8'hA1, 1'b0);
    check_model("post_reset0");
    cycle(1'b1, 1'b0, 8'hA2, 1'b0);
    check_model("post_reset1");
    cycle(1'b1, 1'b1, 8'hA3, 1'b0);
    check_model("post_reset2");
    check("post_reset.cred0", 32'(credits_o), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0),
            8'($urandom),
            1'($urandom_range(0, 2) == 0));
      check_model($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
